cnt_sweep_ctrl: RTL and testbench
=================================

# cnt_sweep_ctrl

Sequencing controller for the team's up/down counter. It drives the counter's enable and direction inputs to sweep the count between a programmable low and high bound, pausing at each bound, for a programmed number of sweeps. It observes the counter's output value and sits between a command source (testbench sequencer or CSR logic) and the counter instance, replacing free-running enable/direction stimulus.

## Interface

Parameters:
- WIDTH, 4, width of the counter value and of the bounds.
- SWEEP_W, 4, width of the sweep-count field.
- HOLD_CYCLES, 2, number of cycles en stays low at each bound pause. Legal range is 1 to 15.

Ports:
- clk, in, 1, the single clock; all logic is rising-edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, command strobe; sampled only in IDLE.
- lo, in, WIDTH, lower bound; latched on accepted start.
- hi, in, WIDTH, upper bound; latched on accepted start.
- sweeps, in, SWEEP_W, number of up-then-down sweeps; 0 means run continuously until abort. Latched on accepted start.
- abort, in, 1, stops an active sequence.
- cnt, in, WIDTH, current counter value, fed back from the counter.
- en, out, 1, counter enable (registered).
- up_dn, out, 1, counter direction: 1 counts up, 0 counts down (registered).
- busy, out, 1, high in every state except IDLE.
- done, out, 1, one-cycle pulse when the final sweep completes.
- err, out, 1, one-cycle pulse when a start is rejected.

## Operation

- States:
  - IDLE: waiting for a command.
  - UP: counting toward hi.
  - HOLD_HI: paused at hi.
  - DOWN: counting toward lo.
  - HOLD_LO: paused at lo.
- The state type and encoding live in a package.
- All outputs are registered from the next state:
  - en = 1 only in UP and DOWN.
  - up_dn = 1 in UP and HOLD_HI; 0 otherwise.
- IDLE, start=1, lo<=hi:
  - Latch lo, hi and sweeps into sweep_left.
  - Go to UP.
- IDLE, start=1, lo>hi: pulse err and stay in IDLE. Nothing is latched.
- UP:
  - Go to HOLD_HI when en=1 and cnt+1==hi, because the counter lands on hi at the same edge.
  - Also go to HOLD_HI immediately when cnt>=hi; en is then never asserted.
  - The compare uses WIDTH+1 bits, so hi=0 does not wrap.
- HOLD_HI:
  - The hold timer loads HOLD_CYCLES on entry.
  - Go to DOWN when the timer reaches 1, giving exactly HOLD_CYCLES cycles with en=0.
- DOWN:
  - The bound is reached when en=1 and cnt==lo+1, or when cnt<=lo.
  - At the bound, if sweep_left==1: go to IDLE and pulse done.
  - At the bound otherwise: decrement sweep_left (except when it is 0, meaning continuous) and go to HOLD_LO.
- HOLD_LO: same timing as HOLD_HI, then go to UP.
- The counter therefore never wraps under controller command. Stopping points are exactly hi and lo.
- abort in any state other than IDLE:
  - Go to IDLE next edge; en=0 after that edge.
  - No done pulse.
  - abort has priority over every transition. abort in IDLE is ignored.
- start while busy is ignored and produces no err.
- lo and hi changing while busy have no effect.

## Timing

- Reset values:
  - en=0, up_dn=0, busy=0, done=0, err=0.
  - State IDLE, sweep_left=0, hold timer=0.
  - Reset mid-sequence returns everything to these values asynchronously. The counter then holds.
- Start latency: start sampled at edge t gives en=1, up_dn=1, busy=1 after edge t. The counter's first step happens at edge t+1.
- Overshoot: zero. The counter's final step and en falling happen on the same edge.
- done is high for one cycle, concurrently with busy falling and en=0.
- err is high for the cycle after the rejecting edge.

## Structure

- Package cnt_sweep_pkg holds:
  - The state enum, sweep_state_e.
  - The hold-timer width localparam, HOLD_W = 4.
- Sub-module cnt_hold_timer:
  - Inputs: load (with value HOLD_CYCLES) and tick.
  - Output: expire.
  - Used by both HOLD states.
- The FSM, bound compares and sweep_left counter stay in cnt_sweep_ctrl.
- The bench instantiates the team's up/down counter, with en, up_dn and cnt looped back.

## Test plan

- Reset counter to 0; WIDTH=4, HOLD=2; start with lo=2, hi=5, sweeps=1.
  - Counter climbs 0→5 and stops at 5; en is high for exactly 5 cycles.
  - en is low for 2 cycles.
  - Counter descends 5→2 over 3 cycles.
  - done pulses once; counter remains at 2.
- lo=0, hi=15, sweeps=2: no wrap past 15 or below 0; exactly 2 HOLD_HI visits and 1 HOLD_LO visit; done on the second arrival at 0.
- start with lo=6, hi=3: err pulses one cycle; busy, en and the counter are unchanged.
- sweeps=0 with lo=1, hi=3: cycles indefinitely.
  - abort asserted mid-UP: en=0 after the next edge, busy=0, no done.
  - The counter stays within 1..3 throughout.
- lo=hi=4 with counter at 4: en is never asserted; busy lasts exactly HOLD_CYCLES+2 cycles; done pulses.
- rst_n asserted mid-DOWN: all outputs go to their reset values immediately. After release, a new start=1 is accepted on the first edge.

Source files
------------

// File: rtl/cnt_sweep_pkg.sv
// Shared types for the counter sweep controller.
//   sweep_state_e : controller state (IDLE, UP, HOLD_HI, DOWN, HOLD_LO)
//   HOLD_W        : width of the bound-pause timer
//   is_hold()     : true for either pause state
package cnt_sweep_pkg;

  localparam int unsigned HOLD_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_UP      = 3'd1,
    ST_HOLD_HI = 3'd2,
    ST_DOWN    = 3'd3,
    ST_HOLD_LO = 3'd4
  } sweep_state_e;

  function automatic logic is_hold(input sweep_state_e s);
    return (s == ST_HOLD_HI) || (s == ST_HOLD_LO);
  endfunction

endpackage

// File: rtl/cnt_hold_timer.sv
// Pause timer used at both sweep bounds.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : reload the timer with HOLD_CYCLES (pause entry)
//   tick       : count down by one while pausing
//   expire     : timer holds 1, i.e. this is the last pause cycle
module cnt_hold_timer
  import cnt_sweep_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic tick,
  output logic expire
);

  localparam logic [HOLD_W-1:0] LOAD_VAL = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] ONE_H    = HOLD_W'(1);

  logic [HOLD_W-1:0] count_q;
  logic [HOLD_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = LOAD_VAL;
    end else if (tick && (count_q != '0)) begin
      count_d = count_q - ONE_H;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Loaded on entry, so the pause lasts exactly HOLD_CYCLES cycles.
  assign expire = (count_q == ONE_H);

endmodule

// File: rtl/cnt_sweep_ctrl.sv
// Sequencing controller for the up/down counter: sweeps the count between
// a latched low and high bound, pausing HOLD_CYCLES at each bound, for a
// latched number of sweeps (0 = continuous until abort).
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : command strobe, only sampled in IDLE
//   lo, hi     : bounds, latched on an accepted start (lo <= hi)
//   sweeps     : up-then-down sweep count, latched on an accepted start
//   abort      : return to IDLE from any active state, no done
//   cnt        : counter value fed back from the counter
//   en, up_dn  : counter enable / direction (registered)
//   busy       : not IDLE
//   done       : one-cycle pulse after the final sweep
//   err        : one-cycle pulse after a rejected start (lo > hi)
module cnt_sweep_ctrl
  import cnt_sweep_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SWEEP_W     = 4,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   lo,
  input  logic [WIDTH-1:0]   hi,
  input  logic [SWEEP_W-1:0] sweeps,
  input  logic               abort,
  input  logic [WIDTH-1:0]   cnt,
  output logic               en,
  output logic               up_dn,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic [WIDTH:0]   ONE_W = (WIDTH+1)'(1);
  localparam logic [SWEEP_W-1:0] ONE_S = SWEEP_W'(1);

  sweep_state_e       state_q, state_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [SWEEP_W-1:0] sweep_left_q, sweep_left_d;
  logic               en_q, en_d;
  logic               up_dn_q, up_dn_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  // Bound compares are one bit wider so hi=0 / lo=max cannot wrap.
  logic [WIDTH:0] cnt_w;
  logic [WIDTH:0] cnt_nx;
  logic           hi_reached;
  logic           lo_reached;

  logic hold_load;
  logic hold_tick;
  logic hold_expire;

  assign cnt_w = {1'b0, cnt};

  // The counter steps on the same edge the controller acts, so a bound is
  // also "reached" one count early while en is high: zero overshoot.
  assign hi_reached = (cnt_w >= {1'b0, hi_q}) ||
                      (en_q && ((cnt_w + ONE_W) == {1'b0, hi_q}));
  assign lo_reached = (cnt_w <= {1'b0, lo_q}) ||
                      (en_q && (cnt_w == ({1'b0, lo_q} + ONE_W)));

  // Counter value after the coming edge.
  always_comb begin
    cnt_nx = cnt_w;
    if (en_q) begin
      cnt_nx = up_dn_q ? (cnt_w + ONE_W) : (cnt_w - ONE_W);
    end
  end

  always_comb begin
    state_d      = state_q;
    lo_d         = lo_q;
    hi_d         = hi_q;
    sweep_left_d = sweep_left_q;
    done_d       = 1'b0;
    err_d        = 1'b0;

    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (lo <= hi) begin
              lo_d         = lo;
              hi_d         = hi;
              sweep_left_d = sweeps;
              state_d      = ST_UP;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_UP: begin
          if (hi_reached) begin
            state_d = ST_HOLD_HI;
          end
        end
        ST_HOLD_HI: begin
          if (hold_expire) begin
            state_d = ST_DOWN;
          end
        end
        ST_DOWN: begin
          if (lo_reached) begin
            if (sweep_left_q == ONE_S) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              if (sweep_left_q != '0) begin
                sweep_left_d = sweep_left_q - ONE_S;
              end
              state_d = ST_HOLD_LO;
            end
          end
        end
        ST_HOLD_LO: begin
          if (hold_expire) begin
            state_d = ST_UP;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // en is only raised on entry to UP/DOWN if the counter is not already
    // at (or past) the target bound; while staying in UP/DOWN the bound
    // compares above guarantee this holds.
    en_d    = ((state_d == ST_UP)   && (cnt_nx < {1'b0, hi_d})) ||
              ((state_d == ST_DOWN) && (cnt_nx > {1'b0, lo_d}));
    up_dn_d = (state_d == ST_UP) || (state_d == ST_HOLD_HI);
    busy_d  = (state_d != ST_IDLE);
  end

  assign hold_load = ((state_d == ST_HOLD_HI) && (state_q != ST_HOLD_HI)) ||
                     ((state_d == ST_HOLD_LO) && (state_q != ST_HOLD_LO));
  assign hold_tick = is_hold(state_q);

  cnt_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (hold_load),
    .tick  (hold_tick),
    .expire(hold_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      lo_q         <= '0;
      hi_q         <= '0;
      sweep_left_q <= '0;
      en_q         <= 1'b0;
      up_dn_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      lo_q         <= lo_d;
      hi_q         <= hi_d;
      sweep_left_q <= sweep_left_d;
      en_q         <= en_d;
      up_dn_q      <= up_dn_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign en    = en_q;
  assign up_dn = up_dn_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_cnt_sweep_ctrl.sv
module tb_cnt_sweep_ctrl;

  localparam int WIDTH   = 4;
  localparam int SWEEP_W = 4;
  localparam int HOLD    = 2;

  typedef struct packed {
    logic             en;
    logic             up_dn;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] cnt;
  } snap_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [WIDTH-1:0]   lo_i;
  logic [WIDTH-1:0]   hi_i;
  logic [SWEEP_W-1:0] sweeps_i;
  logic               abort;
  logic [WIDTH-1:0]   cnt;
  logic               en, up_dn, busy, done, err;

  logic               cnt_ld;
  logic [WIDTH-1:0]   cnt_ld_val;

  int n_cmp = 0;
  int n_bad = 0;

  snap_t exp_q[$];

  always #5 clk = ~clk;

  // Up/down counter driven by the controller; not reset by rst_n.
  always @(posedge clk) begin
    if (cnt_ld) cnt <= cnt_ld_val;
    else if (en) cnt <= up_dn ? cnt + 1'b1 : cnt - 1'b1;
  end

  cnt_sweep_ctrl #(
    .WIDTH(WIDTH),
    .SWEEP_W(SWEEP_W),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .lo(lo_i), .hi(hi_i),
    .sweeps(sweeps_i), .abort(abort), .cnt(cnt), .en(en), .up_dn(up_dn),
    .busy(busy), .done(done), .err(err)
  );

  function automatic snap_t mk(bit e, bit u, bit b, bit d, bit er, int c);
    snap_t s;
    s.en = e; s.up_dn = u; s.busy = b; s.done = d; s.err = er;
    s.cnt = WIDTH'(c);
    return s;
  endfunction

  function automatic snap_t get_obs();
    snap_t s;
    s.en = en; s.up_dn = up_dn; s.busy = busy; s.done = done; s.err = err;
    s.cnt = cnt;
    return s;
  endfunction

  // Expected per-cycle trace (values just after each edge, starting at the
  // edge accepting start), built phase by phase from the sweep rules.
  task automatic build_model(input int c0, input int lo_v, input int hi_v,
                             input int sw, input int cap);
    int c;
    int rem;
    bit fin;
    exp_q.delete();
    c = c0; rem = sw; fin = 0;
    while (!fin && exp_q.size() < cap) begin
      if (c < hi_v) begin
        while (c < hi_v) begin exp_q.push_back(mk(1,1,1,0,0,c)); c++; end
      end else begin
        exp_q.push_back(mk(0,1,1,0,0,c));
      end
      repeat (HOLD) exp_q.push_back(mk(0,1,1,0,0,c));
      if (c > lo_v) begin
        while (c > lo_v) begin exp_q.push_back(mk(1,0,1,0,0,c)); c--; end
      end else begin
        exp_q.push_back(mk(0,0,1,0,0,c));
      end
      if (rem == 1) begin
        exp_q.push_back(mk(0,0,0,1,0,c));
        fin = 1;
      end else begin
        if (rem != 0) rem--;
        repeat (HOLD) exp_q.push_back(mk(0,0,1,0,0,c));
      end
    end
  endtask

  task automatic cmp(input string name, input int cyc, input snap_t o, input snap_t x);
    n_cmp++;
    if (o !== x) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got en=%b up_dn=%b busy=%b done=%b err=%b cnt=%0d, want en=%b up_dn=%b busy=%b done=%b err=%b cnt=%0d",
               name, cyc, o.en, o.up_dn, o.busy, o.done, o.err, o.cnt,
               x.en, x.up_dn, x.busy, x.done, x.err, x.cnt);
    end
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic set_cnt(input int v);
    cnt_ld = 1'b1; cnt_ld_val = WIDTH'(v);
    @(negedge clk);
    cnt_ld = 1'b0;
  endtask

  // Called at a negedge: start is driven at once. abort_min >= 0 aborts at
  // the first UP step at or after that cycle. Random start/lo/hi noise is
  // applied while busy and must have no effect.
  task automatic run_and_check(input string name, input int c0, input int lo_v,
                               input int hi_v, input int sw, input int abort_min,
                               output int en_n, output int busy_n, output int c_end);
    int k;
    int nc;
    snap_t last;
    snap_t o;
    build_model(c0, lo_v, hi_v, sw, (sw == 0) ? 400 : 10000);
    k = -1;
    if (abort_min >= 0) begin
      for (int i = abort_min; i < exp_q.size(); i++) begin
        if (exp_q[i].en && exp_q[i].up_dn) begin k = i; break; end
      end
      if (k < 0) k = abort_min;
      last = exp_q[k];
      nc = int'(last.cnt) + (last.en ? (last.up_dn ? 1 : -1) : 0);
      while (exp_q.size() > k + 1) void'(exp_q.pop_back());
      exp_q.push_back(mk(0,0,0,0,0,nc));
    end
    en_n = 0; busy_n = 0;
    lo_i = WIDTH'(lo_v); hi_i = WIDTH'(hi_v); sweeps_i = SWEEP_W'(sw);
    start = 1'b1; abort = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      o = get_obs();
      cmp(name, i, o, exp_q[i]);
      en_n += int'(o.en);
      busy_n += int'(o.busy);
      abort = (i == k);
      if (exp_q[i].busy && (i != k)) begin
        start    = 1'($urandom_range(0, 1));
        lo_i     = WIDTH'($urandom_range(0, 15));
        hi_i     = WIDTH'($urandom_range(0, 15));
        sweeps_i = SWEEP_W'($urandom_range(0, 15));
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0; abort = 1'b0;
    c_end = int'(exp_q[exp_q.size()-1].cnt);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      cmp({name, "_idle"}, i, get_obs(), mk(0,0,0,0,0,c_end));
    end
  endtask

  task automatic do_reject(input int lo_v, input int hi_v, input int c);
    lo_i = WIDTH'(lo_v); hi_i = WIDTH'(hi_v); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cmp("reject_err", 0, get_obs(), mk(0,0,0,0,1,c));
    @(negedge clk);
    cmp("reject_after", 1, get_obs(), mk(0,0,0,0,0,c));
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    lo_i = '0; hi_i = '0; sweeps_i = '0;
    cnt_ld = 1'b1; cnt_ld_val = '0;
    repeat (2) @(negedge clk);
    cnt_ld = 1'b0;
    cmp("reset_hold", 0, get_obs(), mk(0,0,0,0,0,0));
    rst_n = 1'b1;
    @(negedge clk);
    cmp("reset_release", 1, get_obs(), mk(0,0,0,0,0,0));
  endtask

  task automatic test_basic();
    int en_n, busy_n, c_end;
    set_cnt(0);
    run_and_check("basic", 0, 2, 5, 1, -1, en_n, busy_n, c_end);
    n_cmp++;
    if (en_n !== 8) begin
      n_bad++;
      $display("FAIL basic_en_cycles: got %0d, want 8", en_n);
    end
    n_cmp++;
    if (busy_n !== 10) begin
      n_bad++;
      $display("FAIL basic_busy_cycles: got %0d, want 10", busy_n);
    end
  endtask

  task automatic test_full_range();
    int en_n, busy_n, c_end;
    set_cnt(0);
    run_and_check("full_range", 0, 0, 15, 2, -1, en_n, busy_n, c_end);
  endtask

  task automatic test_reject();
    set_cnt(9);
    do_reject(6, 3, 9);
  endtask

  task automatic test_continuous_abort();
    int en_n, busy_n, c_end;
    set_cnt(1);
    run_and_check("cont_abort", 1, 1, 3, 0, int'($urandom_range(15, 60)),
                  en_n, busy_n, c_end);
  endtask

  task automatic test_equal_bounds();
    int en_n, busy_n, c_end;
    set_cnt(4);
    run_and_check("equal_bounds", 4, 4, 4, 1, -1, en_n, busy_n, c_end);
    n_cmp++;
    if (busy_n !== HOLD + 2) begin
      n_bad++;
      $display("FAIL equal_bounds_busy: got %0d, want %0d", busy_n, HOLD + 2);
    end
    n_cmp++;
    if (en_n !== 0) begin
      n_bad++;
      $display("FAIL equal_bounds_en: got %0d, want 0", en_n);
    end
  endtask

  task automatic test_reset_mid();
    int d, held, en_n, busy_n, c_end;
    set_cnt(0);
    build_model(0, 0, 9, 1, 10000);
    d = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].en && !exp_q[i].up_dn) begin d = i; break; end
    end
    d += int'($urandom_range(0, 5));
    lo_i = 4'd0; hi_i = 4'd9; sweeps_i = 4'd1; start = 1'b1;
    for (int i = 0; i <= d; i++) begin
      @(negedge clk);
      start = 1'b0;
      cmp("reset_mid_run", i, get_obs(), exp_q[i]);
    end
    held = int'(exp_q[d].cnt);
    #2 rst_n = 1'b0;
    #1 cmp("reset_mid_async", 0, get_obs(), mk(0,0,0,0,0,held));
    @(negedge clk);
    cmp("reset_mid_hold", 1, get_obs(), mk(0,0,0,0,0,held));
    rst_n = 1'b1;
    run_and_check("reset_mid_restart", held, 1, 12, 1, -1, en_n, busy_n, c_end);
  endtask

  task automatic test_random();
    int c0, lv, hv, sw, en_n, busy_n, c_end;
    for (int r = 0; r < 8; r++) begin
      c0 = int'($urandom_range(0, 15));
      lv = int'($urandom_range(0, 15));
      hv = int'($urandom_range(0, 15));
      sw = int'($urandom_range(1, 3));
      set_cnt(c0);
      if (lv > hv) do_reject(lv, hv, c0);
      else run_and_check("random", c0, lv, hv, sw, -1, en_n, busy_n, c_end);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_full_range();
    test_reject();
    test_continuous_abort();
    test_equal_bounds();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
